// File: rtl/mvu_vrf_if.sv
// Write/read port bundle for the banked MVU vector register file.
// The master side is the instruction decoder; the slave side is the VRF.
interface mvu_vrf_if #(
   parameter int DW      = 32,
   parameter int AW      = 9,
   parameter int NUM_RAM = 4,
   parameter int VRFIDW  = 2,
   parameter int RW      = DW / NUM_RAM
);
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic [NUM_RAM-1:0] wr_bank_mask;
   logic               rd_en;
   logic [AW-1:0]      rd_addr;
   logic [VRFIDW-1:0]  rd_id;
   logic [RW-1:0]      rd_data;
   logic               rd_valid;
   logic               rd_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_bank_mask, rd_en, rd_addr, rd_id,
      input  rd_data, rd_valid, rd_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_bank_mask, rd_en, rd_addr, rd_id,
      output rd_data, rd_valid, rd_err
   );
endinterface

// File: rtl/mvu_vrf_banked.sv
// Banked MVU vector register file: per-bank write mask, RD_LAT of 1 or 2, sticky bad-bank flag.
// Optional same-cycle write-to-read forwarding when MVU_VRF_BYPASS_EN is defined.
module mvu_vrf_banked #(
   parameter int DW      = 32,
   parameter int DEPTH   = 512,
   parameter int AW      = 9,
   parameter int NUM_RAM = 4,
   parameter int RW      = DW / NUM_RAM,
   parameter int VRFIDW  = 2,
   parameter int RD_LAT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   mvu_vrf_if.slave   bus
);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("mvu_vrf_banked: RD_LAT must be 1 or 2");
   end
   if (DW % NUM_RAM != 0) begin : g_bad_dw
      $error("mvu_vrf_banked: DW must be a multiple of NUM_RAM");
   end

   logic [RW-1:0]      mem_q [NUM_RAM][DEPTH];
   logic [NUM_RAM-1:0] bank_we_d;
   logic [RW-1:0]      word_p0_d [NUM_RAM];
   logic               wr_in_range;
   logic               rd_in_range;
   logic               rd_fire;
   logic               id_oor;

   logic               out_vld;
   logic [VRFIDW-1:0]  out_id;
   logic [RW-1:0]      out_word [NUM_RAM];

   logic [RW-1:0]      rd_data_d, rd_data_q;
   logic               rd_valid_d, rd_valid_q;
   logic               rd_err_d, rd_err_q;

   // Stage 0: address decode, bank write enables, raw bank read
   always_comb begin
      wr_in_range = 32'(bus.wr_addr) < DEPTH;
      rd_in_range = 32'(bus.rd_addr) < DEPTH;
      rd_fire     = bus.rd_en && !rst;
      id_oor      = 32'(bus.rd_id) >= NUM_RAM;
      for (int i = 0; i < NUM_RAM; i++) begin
         bank_we_d[i] = bus.wr_en && bus.wr_bank_mask[i] && wr_in_range && !rst;
         word_p0_d[i] = rd_in_range ? mem_q[i][bus.rd_addr] : '0;
`ifdef MVU_VRF_BYPASS_EN
         if (bank_we_d[i] && (bus.wr_addr == bus.rd_addr)) begin
            word_p0_d[i] = bus.wr_data[i*RW +: RW];
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RAM; i++) begin
         if (bank_we_d[i]) begin
            mem_q[i][bus.wr_addr] <= bus.wr_data[i*RW +: RW];
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              vld_p0_d, vld_p0_q;
      logic [VRFIDW-1:0] id_p0_d, id_p0_q;
      logic [RW-1:0]     word_p0_q [NUM_RAM];

      always_comb begin
         vld_p0_d = rd_fire;
         id_p0_d  = rd_fire ? bus.rd_id : id_p0_q;
      end

      // Stage 1: registered bank outputs; id/valid carried alongside
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_p0_q <= 1'b0;
            id_p0_q  <= '0;
         end else begin
            vld_p0_q <= vld_p0_d;
            id_p0_q  <= id_p0_d;
         end
      end

      always_ff @(posedge clk) begin
         if (rd_fire) begin
            word_p0_q <= word_p0_d;
         end
      end

      assign out_vld  = vld_p0_q;
      assign out_id   = id_p0_q;
      assign out_word = word_p0_q;
   end else begin : g_lat1
      assign out_vld  = rd_fire;
      assign out_id   = bus.rd_id;
      assign out_word = word_p0_d;
   end

   // Output stage: bank select; an id past the last bank selects nothing and yields 0
   always_comb begin
      rd_valid_d = out_vld;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q || (rd_fire && id_oor);
      if (out_vld) begin
         rd_data_d = '0;
         for (int i = 0; i < NUM_RAM; i++) begin
            if (out_id == VRFIDW'(i)) begin
               rd_data_d = out_word[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_err   = rd_err_q;

endmodule

// File: doc/mvu_vrf_banked.md
# mvu_vrf_banked

Parametrised banked vector register file for the MVU tiles. Replaces the fixed-latency single-mask VRF with:
- per-bank write masking;
- selectable read latency;
- a read-valid pipeline;
- out-of-range bank detection;
- optional same-cycle write-to-read forwarding.

It sits between the MVU instruction decoder's VRF write/read ports and the dot-product lanes, supplying one RW-bit bank slice per read.

## Interface

Parameters:
- DW, 32: full write-word width; must be a multiple of NUM_RAM.
- DEPTH, 512: words per bank.
- AW, 9: address width; DEPTH ≤ 2^AW.
- NUM_RAM, 4: number of banks.
- RW, DW/NUM_RAM: bank slice width; also the read data width.
- VRFIDW, 2: bank-select width; 2^VRFIDW ≥ NUM_RAM.
- RD_LAT, 2: read latency in cycles. 1 means RAM output is unregistered; 2 means RAM output is registered. No other values are legal; elaboration errors otherwise.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- wr_en  in  1: write strobe.
- wr_addr  in  AW: write address, common to all banks.
- wr_data  in  DW: bank i takes wr_data[i*RW +: RW].
- wr_bank_mask  in  NUM_RAM: bank i is written only when wr_en && wr_bank_mask[i].
- rd_en  in  1: read strobe.
- rd_addr  in  AW: read address.
- rd_id  in  VRFIDW: bank select.
- rd_data  out  RW: selected bank word.
- rd_valid  out  1: rd_data is valid this cycle.
- rd_err  out  1: sticky out-of-range flag.

## Operation

Storage:
- NUM_RAM independent DEPTH×RW simple dual-port arrays, one write port and one read port each.
- Contents are not cleared by rst.

Write:
- In cycle T, bank i stores its slice at wr_addr when wr_en && wr_bank_mask[i].
- The write is visible to any read sampled in T+1 or later.
- wr_addr ≥ DEPTH is ignored; no bank changes.

Read:
- In cycle T, when rd_en is high, rd_addr and rd_id are sampled.
- All banks are read at rd_addr. rd_id and rd_en travel down a RD_LAT-deep shift pipeline alongside the RAM read.
- At the output stage, rd_data = slice of the bank selected by the delayed rd_id.

Out-of-range bank:
- Applies when rd_id ≥ NUM_RAM at sampling.
- That read still returns rd_valid=1, with rd_data=0.
- rd_err sets in the cycle the read is sampled, i.e. high from T+1.
- rd_err stays high until rst.

Output hold:
- rd_data updates only in cycles where rd_valid=1.
- Otherwise rd_data holds its last value.

Simultaneous events:
- Read and write in the same cycle to different addresses: independent.
- Read and write to the same address: governed by Configuration.

Reset:
- rst clears rd_valid, rd_data, rd_err and the id/valid pipeline to 0.
- Reads in flight at reset are dropped: no rd_valid for them, ever.
- A read or write presented in the same cycle as rst is ignored.

## Timing

- Read latency is exactly RD_LAT. Read sampled at T gives rd_valid=1 and data at T+RD_LAT.
- Throughput is one read per cycle, sustained, with no bubbles. Back-to-back reads emerge in order, one per cycle.
- Write-to-read latency is 1: a write at T is readable by a read sampled at T+1.
- Reset values: rd_data=0, rd_valid=0, rd_err=0. They hold for as long as rst is high.
- First valid output after rst deasserts is at the cycle of the first post-reset read plus RD_LAT.
- Combinational paths: none from inputs to outputs. All outputs are registered or driven from RAM output registers.

## Configuration

Macro: MVU_VRF_BYPASS_EN.

Defined:
- Same-cycle write→read forwarding, evaluated per bank.
- If a read samples rd_addr == wr_addr in the same cycle that bank i is written, the read returns the new slice for bank i.
- Banks not written in that cycle return stored data.
- Forwarded data follows the same RD_LAT pipeline.

Undefined:
- Mixed-port read-during-write returns unspecified data for the written banks.
- The bench must not check that data; no other behaviour changes.

## Test plan

1. Masked write: write addr 5, wr_data={40,30,20,10} (bank3..0), mask 4'b1111; read addr 5 with rd_id=0..3 on consecutive cycles. Expect 10, 20, 30, 40 at T+RD_LAT..T+RD_LAT+3, rd_valid high 4 cycles.
2. Partial write: after test 1, write addr 5 data {99,99,99,99} mask 4'b0100; read all four banks. Expect 10, 20, 99, 40.
3. Forwarding (MVU_VRF_BYPASS_EN): bank1@7 holds 3; same cycle write addr 7 bank1=55 mask 4'b0010, read addr 7 rd_id=1. Expect 55 at T+RD_LAT. Without the macro, the data is unchecked but rd_valid=1.
4. Out-of-range bank (NUM_RAM=3, VRFIDW=2): read rd_id=3. Expect rd_data=0, rd_valid=1 at T+RD_LAT, rd_err=1 from T+1 and staying high; a following good read still returns correct data.
5. Reset mid-read: issue reads at T and T+1 with RD_LAT=2, assert rst at T+1. Expect rd_valid=0 through T+3, rd_data=0, rd_err cleared, and a later write at addr 5 (test 1 pattern) rereads correctly.
6. Streaming: 16 back-to-back reads of addr 0..15 with rd_id cycling 0..3, after filling the banks. Expect 16 consecutive rd_valid cycles in order; run with RD_LAT=1 and RD_LAT=2.
